// File: rtl/slave_memory_piped_if.sv
// Request/response bus for slave_memory_piped.
// master: drives wen/ren/addr/wdata, receives rdata/rvalid/rerr/ready.
// slave : the memory side of the same signals.
interface slave_memory_piped_if #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  wen;
   logic                  ren;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  rerr;
   logic                  ready;

   modport master (
      output wen, ren, addr, wdata,
      input  rdata, rvalid, rerr, ready
   );

   modport slave (
      input  wen, ren, addr, wdata,
      output rdata, rvalid, rerr, ready
   );
endinterface

// File: rtl/slave_memory_piped.sv
// Pipelined single-port word memory slave.
// Ports: clk, rstn (async active-low), bus (slave_memory_piped_if.slave):
//   wen/ren/addr/wdata requests accepted when ready=1; rdata/rerr qualified by a
//   one-cycle rvalid pulse READ_LATENCY cycles after the accepting edge.
// Optional macro SLAVE_MEM_CLEAR_EN: zero-fill sweep of the storage after reset,
// one word per cycle, with ready held low until the sweep completes.
module slave_memory_piped #(
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned MEM_SIZE     = 4096,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   slave_memory_piped_if.slave  bus
);
   localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int unsigned LAT   = READ_LATENCY;

   // Storage and its registered read port (no reset, so it maps onto RAM)
   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
   logic [DATA_WIDTH-1:0] mem_rd_q;

   logic                  ready_q, ready_d;
   logic                  wr_acc_c, rd_acc_c, in_range_c;
   logic                  mem_we_c;
   logic [IDX_W-1:0]      mem_idx_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;
   logic                  clr_we_c;
   logic [IDX_W-1:0]      clr_idx_c;

   // Stage 0 tracks the RAM read register; stages 1..LAT carry the response
   logic                  vld0_q, vld0_d, err0_q, err0_d;
   logic [LAT:1]          vld_q, vld_d, err_q, err_d;
   logic [DATA_WIDTH-1:0] dat_q [LAT:1];
   logic [DATA_WIDTH-1:0] dat_d [LAT:1];

`ifdef SLAVE_MEM_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_READY} state_e;
   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

   // Sweep counter walks 0..MEM_SIZE-1 writing zero, then hands over to READY
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we_c  = 1'b0;
      clr_idx_c = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_we_c  = 1'b1;
         clr_cnt_d = clr_cnt_q + IDX_W'(1);
         if (clr_cnt_q == IDX_W'(MEM_SIZE - 1)) state_d = ST_READY;
      end
   end
`else
   always_comb begin
      clr_we_c  = 1'b0;
      clr_idx_c = '0;
   end
`endif

   // Request acceptance, RAM port steering and response pipeline
   always_comb begin
      wr_acc_c    = ready_q & bus.wen;
      rd_acc_c    = ready_q & bus.ren;
      // Full address width decides range; upper bits never reach the index
      in_range_c  = ({1'b0, bus.addr} < (ADDR_WIDTH + 1)'(MEM_SIZE));
      mem_we_c    = clr_we_c | (wr_acc_c & in_range_c);
      mem_idx_c   = clr_we_c ? clr_idx_c : bus.addr[IDX_W-1:0];
      mem_wdata_c = clr_we_c ? '0 : bus.wdata;

`ifdef SLAVE_MEM_CLEAR_EN
      ready_d = (state_d == ST_READY);
`else
      ready_d = 1'b1;
`endif

      vld0_d = rd_acc_c;
      err0_d = rd_acc_c ? ~in_range_c : err0_q;

      // Each stage only loads when a response moves into it, so the last
      // stage holds rdata/rerr between rvalid pulses.
      vld_d[1] = vld0_q;
      err_d[1] = vld0_q ? err0_q : err_q[1];
      dat_d[1] = vld0_q ? (err0_q ? '0 : mem_rd_q) : dat_q[1];
      for (int k = 2; k <= int'(LAT); k++) begin
         vld_d[k] = vld_q[k-1];
         err_d[k] = vld_q[k-1] ? err_q[k-1] : err_q[k];
         dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
      end
   end

   // RAM: write and read share the single address; read-first via NBA
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[mem_idx_c] <= mem_wdata_c;
      if (rd_acc_c) mem_rd_q <= mem[mem_idx_c];
   end

   // Control and response registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ready_q <= 1'b0;
         vld0_q  <= 1'b0;
         err0_q  <= 1'b0;
         vld_q   <= '0;
         err_q   <= '0;
         for (int k = 1; k <= int'(LAT); k++) dat_q[k] <= '0;
`ifdef SLAVE_MEM_CLEAR_EN
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
`endif
      end else begin
         ready_q <= ready_d;
         vld0_q  <= vld0_d;
         err0_q  <= err0_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         for (int k = 1; k <= int'(LAT); k++) dat_q[k] <= dat_d[k];
`ifdef SLAVE_MEM_CLEAR_EN
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
`endif
      end
   end

   assign bus.ready  = ready_q;
   assign bus.rvalid = vld_q[LAT];
   assign bus.rerr   = err_q[LAT];
   assign bus.rdata  = dat_q[LAT];
endmodule

// File: tb/tb_slave_memory_piped.sv
// Directed self-checking bench for slave_memory_piped (READ_LATENCY=2).
// Default build uses MEM_SIZE=2048; with SLAVE_MEM_CLEAR_EN it uses MEM_SIZE=16
// and adds the clear-sweep scenarios.
module tb_slave_memory_piped;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
   localparam int unsigned L  = 2;
`ifdef SLAVE_MEM_CLEAR_EN
   localparam int unsigned MS       = 16;
   localparam int          READY_LAT = 16;
   localparam logic [AW-1:0] A_BASIC = 12'h00A;
   localparam logic [AW-1:0] A_OOR   = 12'h014;
   localparam logic [AW-1:0] A_ALIAS = 12'h004;
   localparam logic [AW-1:0] A_RF    = 12'h00C;
`else
   localparam int unsigned MS       = 2048;
   localparam int          READY_LAT = 1;
   localparam logic [AW-1:0] A_BASIC = 12'h010;
   localparam logic [AW-1:0] A_OOR   = 12'h900;
   localparam logic [AW-1:0] A_ALIAS = 12'h100;
   localparam logic [AW-1:0] A_RF    = 12'h020;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   slave_memory_piped_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   slave_memory_piped #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .READ_LATENCY(L)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled here
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.wen = 1'b1; bus.addr = a; bus.wdata = d;
      cyc();
      bus.wen = 1'b0;
   endtask

   // Issue one read (optionally with a same-cycle write) and check its response timing
   task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] ed,
                           input logic ee, input logic we, input logic [DW-1:0] wd);
      bus.ren = 1'b1; bus.wen = we; bus.addr = a; bus.wdata = wd;
      cyc();
      bus.ren = 1'b0; bus.wen = 1'b0;
      for (int k = 1; k < int'(L); k++) begin
         cyc();
         check({tag, "_early"}, 32'(bus.rvalid), 32'(0));
      end
      cyc();
      check({tag, "_vld"},  32'(bus.rvalid), 32'(1));
      check({tag, "_data"}, 32'(bus.rdata),  32'(ed));
      check({tag, "_err"},  32'(bus.rerr),   32'(ee));
      cyc();
      check({tag, "_pulse"}, 32'(bus.rvalid), 32'(0));
   endtask

   // Count edges after release until ready; optionally hammer requests meanwhile
   task automatic wait_ready(input string tag, input int exp, input logic poke);
      int n = 0;
      if (poke) begin
         bus.wen = 1'b1; bus.ren = 1'b1; bus.addr = 12'h003; bus.wdata = 8'h77;
      end
      do begin
         cyc();
         n++;
      end while (bus.ready !== 1'b1 && n < 5000);
      bus.wen = 1'b0; bus.ren = 1'b0;
      check(tag, 32'(n), 32'(exp));
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_rvalid"}, 32'(bus.rvalid), 32'(0));
      check({tag, "_rerr"},   32'(bus.rerr),   32'(0));
      check({tag, "_rdata"},  32'(bus.rdata),  32'(0));
      check({tag, "_ready"},  32'(bus.ready),  32'(0));
   endtask

   initial begin
      logic [DW-1:0] pat [4];
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = '0; bus.wdata = '0;

      repeat (3) cyc();
      check_reset_outs("rst0");
      rstn = 1'b1;

`ifdef SLAVE_MEM_CLEAR_EN
      // Reset during sweep cycle 8 restarts the full count
      repeat (8) cyc();
      check("sweep8_ready", 32'(bus.ready), 32'(0));
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      wait_ready("ready_lat_restart", READY_LAT, 1'b1);
      for (int k = 0; k <= int'(L); k++) begin
         cyc();
         check($sformatf("sweep_req_ignored%0d", k), 32'(bus.rvalid), 32'(0));
      end
      for (int i = 0; i < int'(MS); i++)
         rd_check($sformatf("clr%0d", i), AW'(i), 8'h00, 1'b0, 1'b0, 8'h00);
`else
      wait_ready("ready_lat", READY_LAT, 1'b0);
`endif

      // Basic write then read
      wr(A_BASIC, 8'hA5);
      rd_check("basic", A_BASIC, 8'hA5, 1'b0, 1'b0, 8'h00);

      // Back-to-back reads, responses on consecutive cycles
      for (int i = 0; i < 4; i++) wr(AW'(i), pat[i]);
      for (int i = 0; i <= 4 + int'(L); i++) begin
         if (i < 4) begin
            bus.ren = 1'b1; bus.addr = AW'(i);
         end else begin
            bus.ren = 1'b0;
         end
         cyc();
         if (i >= int'(L) && i - int'(L) < 4) begin
            check($sformatf("pipe%0d_vld", i), 32'(bus.rvalid), 32'(1));
            check($sformatf("pipe%0d_data", i), 32'(bus.rdata), 32'(pat[i - int'(L)]));
         end else begin
            check($sformatf("pipe%0d_idle", i), 32'(bus.rvalid), 32'(0));
         end
      end

      // Out-of-range write dropped, never aliased onto the low index
      wr(A_ALIAS, 8'h3C);
      wr(A_OOR, 8'hFF);
      rd_check("oor", A_OOR, 8'h00, 1'b1, 1'b0, 8'h00);
      repeat (3) cyc();
      check("oor_hold_err",  32'(bus.rerr),  32'(1));
      check("oor_hold_data", 32'(bus.rdata), 32'(0));
      rd_check("alias", A_ALIAS, 8'h3C, 1'b0, 1'b0, 8'h00);
      repeat (2) cyc();
      check("alias_hold_data", 32'(bus.rdata), 32'(8'h3C));

      // Same-address read+write is read-first
      wr(A_RF, 8'h5A);
      rd_check("rf_old", A_RF, 8'h5A, 1'b0, 1'b1, 8'hC3);
      rd_check("rf_new", A_RF, 8'hC3, 1'b0, 1'b0, 8'h00);

      // Reset with reads in flight: no stale responses afterwards
      bus.ren = 1'b1; bus.addr = 12'h000;
      cyc();
      bus.addr = 12'h001;
      cyc();
      bus.addr = 12'h002;
      rstn = 1'b0;
      #1;
      check_reset_outs("rst_mid");
      bus.ren = 1'b0;
      repeat (2) cyc();
      check_reset_outs("rst_hold");
      rstn = 1'b1;
      wait_ready("ready_lat_mid", READY_LAT, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check($sformatf("no_stale%0d", k), 32'(bus.rvalid), 32'(0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/slave_memory_piped.md
SLAVE_MEMORY_PIPED -- requirements
Module: slave_memory_piped

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, bus address width.
REQ-002 Parameter DATA_WIDTH, default 8, data word width.
REQ-003 Parameter MEM_SIZE, default 4096, words of storage, power of two, at most 2^ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 2, legal range 1..4, cycles from accepted read to rvalid.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rstn  input  1  reset, asynchronous and active-low.
REQ-007 wen  input  1  write request.
REQ-008 ren  input  1  read request.
REQ-009 addr  input  ADDR_WIDTH  word address.
REQ-010 wdata  input  DATA_WIDTH  write data.
REQ-011 rdata  output  DATA_WIDTH  read data, registered.
REQ-012 rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-013 rerr  output  1  qualifies rvalid; 1 = read address was out of range.
REQ-014 ready  output  1  1 = requests are accepted this cycle.

Function
REQ-015 Storage is an inferred synchronous single-port array of MEM_SIZE x DATA_WIDTH; no vendor IP instance.
REQ-016 A request is accepted only on a rising edge where ready=1; wen/ren while ready=0 are ignored with no side effect.
REQ-017 Accepted write with addr < MEM_SIZE stores wdata at addr on that edge.
REQ-018 Accepted write with addr >= MEM_SIZE is dropped; storage unchanged; no response.
REQ-019 Accepted read returns rvalid=1 exactly READ_LATENCY cycles after the accepting edge, for exactly one cycle.
REQ-020 Reads are fully pipelined: one read per cycle, back-to-back, responses in request order, no bubbles.
REQ-021 wen and ren together at the same addr: read-first; rdata returns the old contents, new data is stored.
REQ-022 Read with addr >= MEM_SIZE: rdata=0, rerr=1 with its rvalid; in-range read gives rerr=0.
REQ-023 rdata and rerr hold their last value between rvalid pulses.
REQ-024 Address bits above log2(MEM_SIZE) are used only for the range check, never aliased into storage.

Reset
REQ-025 While rstn=0: rvalid=0, rerr=0, rdata=0, ready=0, and all in-flight read pipeline stages are cleared.
REQ-026 Reset asserted mid-pipeline discards outstanding reads; no rvalid for them after release.
REQ-027 Storage contents are not cleared by reset unless SLAVE_MEM_CLEAR_EN is defined.

Configuration
REQ-028 Macro SLAVE_MEM_CLEAR_EN selects a post-reset clear sweep.
REQ-029 With SLAVE_MEM_CLEAR_EN, a two-state FSM CLEAR -> READY runs. CLEAR is entered on reset. In CLEAR, one word per cycle is written with 0 at a counter address 0..MEM_SIZE-1, with ready=0. After address MEM_SIZE-1 the FSM moves to READY and ready=1 on the following cycle, MEM_SIZE cycles after reset release.
REQ-030 With SLAVE_MEM_CLEAR_EN, reset asserted during CLEAR restarts the sweep from address 0 after release.
REQ-031 Without SLAVE_MEM_CLEAR_EN, there is no FSM or counter: ready=1 from the first rising edge after reset release, and contents are undefined until written.

Verification
REQ-032 Write 0xA5 at addr 0x010, read 0x010 next cycle (READ_LATENCY=2) -> rvalid pulse 2 cycles after the read edge, rdata=0xA5, rerr=0.
REQ-033 Reads at 0x000..0x003 on 4 consecutive cycles, preloaded 0x11,0x22,0x33,0x44 -> 4 consecutive rvalid cycles carrying 0x11,0x22,0x33,0x44.
REQ-034 MEM_SIZE=2048, write 0xFF at 0x900, then read 0x900 -> rvalid with rdata=0x00, rerr=1. Read 0x100 -> unchanged contents.
REQ-035 Addr 0x020 holds 0x5A; wen+ren at 0x020 with wdata 0xC3 -> rdata=0x5A. Subsequent read -> 0xC3.
REQ-036 Three reads issued, rstn pulsed low before first response -> no rvalid after release. All outputs are 0 during reset.
REQ-037 SLAVE_MEM_CLEAR_EN, MEM_SIZE=16: ready=0 for 16 cycles after release. Requests during sweep are ignored. Every address then reads 0x00. Reset at sweep cycle 8 restarts the 16-cycle count.
